// File: rtl/transpose_pkg.sv
// Shared definitions for the transpose tile buffer: default line width, bank states,
// and the counter-width helper used by the top and the bank storage.
package transpose_pkg;

    localparam int unsigned LINE_WIDTH_DEFAULT = 512;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        READY
    } bank_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_bank.sv
// One N x N tile of element storage: row-wide write port, column-wide read port.
module tile_bank
    import transpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 32,
    localparam int unsigned CW        = cnt_width(N)
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [CW-1:0]           i_row,
    input  logic [N*DATA_WIDTH-1:0] i_din,
    input  logic [CW-1:0]           i_col,
    output logic [N*DATA_WIDTH-1:0] o_col
);

    // Storage is intentionally not reset; the bank state in the top qualifies its contents.
    logic [N-1:0][DATA_WIDTH-1:0] r_rows [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rows[i_row] <= i_din;
        end
    end

    always_comb begin
        o_col = '0;
        for (int k = 0; k < N; k++) begin
            o_col[k*DATA_WIDTH +: DATA_WIDTH] = r_rows[k][i_col];
        end
    end

endmodule

// File: rtl/transpose_tile_buffer.sv
// Ping-pong tile buffer: rows are written into one bank while the other bank is read out
// column by column, so each output line is one column of a completed tile.
module transpose_tile_buffer
    import transpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LINE_WIDTH-1:0] input_fifo_din,
    input  logic                  input_fifo_we,
    output logic                  input_fifo_full,
    output logic                  input_fifo_overflow,
    output logic [LINE_WIDTH-1:0] output_fifo_dout,
    input  logic                  output_fifo_re,
    output logic                  output_fifo_empty
);

    localparam int unsigned N  = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned CW = cnt_width(N);

    bank_state_e r_state [2];
    bank_state_e w_state_nxt [2];

    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [CW-1:0] r_wr_row;
    logic [CW-1:0] r_rd_col;
    logic          r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic [1:0]            w_bank_we;
    logic [LINE_WIDTH-1:0] w_bank_col [2];

    assign w_full    = (r_state[r_wr_bank] == READY);
    assign w_empty   = (r_state[r_rd_bank] != READY);
    assign w_wr_acc  = input_fifo_we && !w_full;
    assign w_pop     = output_fifo_re && !w_empty;
    assign w_wr_last = (r_wr_row == CW'(N - 1));
    assign w_rd_last = (r_rd_col == CW'(N - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_we[b] = w_wr_acc && (r_wr_bank == 1'(b));

        tile_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .N         (N)
        ) u_bank (
            .clk  (clk),
            .i_we (w_bank_we[b]),
            .i_row(r_wr_row),
            .i_din(input_fifo_din),
            .i_col(r_rd_col),
            .o_col(w_bank_col[b])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= FREE;
            r_state[1] <= FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A write only ever targets a non-READY bank and a pop only a READY one, so a tile
    // completing and the other tile draining in the same cycle never touch the same bank.
    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_acc) begin
            w_state_nxt[r_wr_bank] = w_wr_last ? READY : FILLING;
        end
        if (w_pop && w_rd_last) begin
            w_state_nxt[r_rd_bank] = FREE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_row   <= '0;
            r_rd_col   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_row <= w_wr_last ? '0 : r_wr_row + CW'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_pop) begin
                r_rd_col <= w_rd_last ? '0 : r_rd_col + CW'(1);
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
            if (input_fifo_we && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        input_fifo_full     = w_full;
        input_fifo_overflow = r_overflow;
        output_fifo_empty   = w_empty;
        output_fifo_dout    = reset ? '0 : w_bank_col[r_rd_bank];
    end

endmodule

// File: tb/tb_transpose_tile_buffer.sv
// Randomised and directed bench for transpose_tile_buffer; a tile-level reference model
// pushes expected transposed lines into a queue that a negedge monitor pops and compares.
module tb_transpose_tile_buffer;

    localparam int DW   = 16;
    localparam int LW   = 512;
    localparam int N    = LW / DW;
    localparam int DW32 = 32;
    localparam int N32  = LW / DW32;

    logic          clk = 1'b0;
    logic          reset;
    logic [LW-1:0] din;
    logic          we;
    logic          re;
    logic          full;
    logic          ovf;
    logic [LW-1:0] dout;
    logic          empty;

    logic          reset32;
    logic [LW-1:0] din32;
    logic          we32;
    logic          re32;
    logic          full32;
    logic          ovf32;
    logic [LW-1:0] dout32;
    logic          empty32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    transpose_tile_buffer #(
        .DATA_WIDTH(DW),
        .LINE_WIDTH(LW)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .input_fifo_din     (din),
        .input_fifo_we      (we),
        .input_fifo_full    (full),
        .input_fifo_overflow(ovf),
        .output_fifo_dout   (dout),
        .output_fifo_re     (re),
        .output_fifo_empty  (empty)
    );

    transpose_tile_buffer #(
        .DATA_WIDTH(DW32),
        .LINE_WIDTH(LW)
    ) u_dut32 (
        .clk                (clk),
        .reset              (reset32),
        .input_fifo_din     (din32),
        .input_fifo_we      (we32),
        .input_fifo_full    (full32),
        .input_fifo_overflow(ovf32),
        .output_fifo_dout   (dout32),
        .output_fifo_re     (re32),
        .output_fifo_empty  (empty32)
    );

    function automatic void chk(input string name, input logic [LW-1:0] act,
                                input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a tile is a plain array of rows; a finished tile yields N lines.
    logic [LW-1:0] m_tile [N];
    logic [LW-1:0] exp_q [$];
    int            m_row   = 0;
    int            m_lines = 0;
    bit            m_ovf   = 1'b0;

    always @(posedge clk or posedge reset) begin : p_model
        bit            full_now;
        logic [LW-1:0] line;
        if (reset) begin
            m_row   = 0;
            m_lines = 0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            full_now = (m_lines > N);
            if (re && m_lines > 0) m_lines--;
            if (we) begin
                if (full_now) begin
                    m_ovf = 1'b1;
                end else begin
                    m_tile[m_row] = din;
                    m_row++;
                    if (m_row == N) begin
                        m_row = 0;
                        for (int c = 0; c < N; c++) begin
                            for (int k = 0; k < N; k++) begin
                                line[k*DW +: DW] = m_tile[k][c*DW +: DW];
                            end
                            exp_q.push_back(line);
                        end
                        m_lines += N;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_dout", dout, '0);
            chk("rst_empty", LW'(empty), LW'(1));
            chk("rst_full", LW'(full), '0);
            chk("rst_ovf", LW'(ovf), '0);
        end else begin
            chk("empty", LW'(empty), LW'(exp_q.size() == 0));
            chk("full", LW'(full), LW'(exp_q.size() > N));
            chk("overflow", LW'(ovf), LW'(m_ovf));
            if (re && exp_q.size() > 0) chk("line", dout, exp_q.pop_front());
        end
    end

    logic [LW-1:0] q32 [$];

    always @(negedge clk) begin
        if (!reset32) begin
            chk("empty32", LW'(empty32), LW'(q32.size() == 0));
            if (re32 && q32.size() > 0) chk("line32", dout32, q32.pop_front());
        end
    end

    function automatic logic [LW-1:0] pat_row(input int r);
        logic [LW-1:0] v;
        logic [7:0]    rb;
        logic [7:0]    cb;
        rb = 8'(r);
        for (int c = 0; c < N; c++) begin
            cb = 8'(c);
            v[c*DW +: DW] = {rb, cb};
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step(input logic w, input logic r, input logic [LW-1:0] d);
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        we      = 1'b0;
        re      = 1'b0;
        din     = '0;
        reset32 = 1'b1;
        we32    = 1'b0;
        re32    = 1'b0;
        din32   = '0;
        #1;
        do_reset(3);

        // Single tile with pops held high; empty must drop right after the 32nd write.
        for (int r = 0; r < N; r++) begin
            step(1'b1, 1'b1, pat_row(r));
            if (r == N - 2) chk("latency_pre", LW'(empty), LW'(1));
        end
        chk("latency_post", LW'(empty), '0);
        repeat (N + 4) step(1'b0, 1'b1, '0);

        // Three tiles streamed back to back with continuous pops.
        for (int r = 0; r < 3 * N; r++) step(1'b1, 1'b1, rand_line());
        repeat (N + 4) step(1'b0, 1'b1, '0);

        // Fill both banks, overflow, then free one bank and write again.
        for (int r = 0; r < 2 * N; r++) step(1'b1, 1'b0, pat_row(r));
        chk("full_after_64", LW'(full), LW'(1));
        step(1'b1, 1'b0, rand_line());
        chk("ovf_after_65", LW'(ovf), LW'(1));
        repeat (N) step(1'b0, 1'b1, '0);
        chk("full_after_pops", LW'(full), '0);
        step(1'b1, 1'b0, pat_row(7));
        repeat (N + 4) step(1'b0, 1'b1, '0);
        do_reset(2);

        // Pops while empty, then a reset mid-tile, then a clean tile.
        repeat (3) step(1'b0, 1'b1, '0);
        for (int r = 0; r < 10; r++) step(1'b1, 1'b0, rand_line());
        do_reset(2);
        for (int r = 0; r < N; r++) step(1'b1, 1'b0, pat_row(r + 5));
        repeat (N + 4) step(1'b0, 1'b1, '0);

        // Final row of tile B lands in the same cycle as the final pop of tile A.
        for (int r = 0; r < N; r++) step(1'b1, 1'b0, rand_line());
        for (int r = 0; r < N - 1; r++) step(1'b1, 1'b0, rand_line());
        repeat (N - 1) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, rand_line());
        chk("tileb_ready", LW'(empty), '0);
        repeat (N + 4) step(1'b0, 1'b1, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 10) < 7), 1'(($urandom % 10) < 6), rand_line());
        end
        repeat (3 * N) step(1'b0, 1'b1, '0);
        chk("drain", LW'(exp_q.size()), '0);

        // 32-bit elements, 16x16 tile.
        #1;
        reset32 = 1'b0;
        for (int r = 0; r < N32; r++) begin
            for (int c = 0; c < N32; c++) din32[c*DW32 +: DW32] = {16'(r), 16'(c)};
            we32 = 1'b1;
            @(posedge clk);
            #1;
        end
        we32 = 1'b0;
        for (int c = 0; c < N32; c++) begin
            logic [LW-1:0] line;
            for (int k = 0; k < N32; k++) line[k*DW32 +: DW32] = {16'(k), 16'(c)};
            q32.push_back(line);
        end
        re32 = 1'b1;
        repeat (N32 + 4) begin
            @(posedge clk);
            #1;
        end
        re32 = 1'b0;
        chk("drain32", LW'(q32.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transpose_tile_buffer.md
TRANSPOSE_TILE_BUFFER -- requirements
Module: transpose_tile_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter LINE_WIDTH, default 512, line width in bits; SHALL be a multiple of DATA_WIDTH.
REQ-003 SHALL derive localparam N = LINE_WIDTH/DATA_WIDTH, the elements per line and the tile side (N lines x N elements).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 input_fifo_din  input  LINE_WIDTH  one tile row; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 input_fifo_we  input  1  write strobe; accepted when input_fifo_full is low.
REQ-008 input_fifo_full  output  1  high when no bank can accept a row.
REQ-009 input_fifo_overflow  output  1  sticky; set by a write while full.
REQ-010 output_fifo_dout  output  LINE_WIDTH  current transposed line, first-word-fall-through.
REQ-011 output_fifo_re  input  1  pop strobe; effective only when output_fifo_empty is low.
REQ-012 output_fifo_empty  output  1  high when no transposed line is available.

Function
REQ-013 SHALL hold two tile banks (ping-pong), each with state FREE, FILLING or READY.
REQ-014 An accepted write SHALL store din as row wr_row of bank wr_bank; wr_row then increments.
REQ-015 When row N-1 is written, the bank SHALL become READY; wr_bank toggles and wr_row resets to 0.
REQ-016 input_fifo_full SHALL be high exactly when bank wr_bank is READY.
REQ-017 A write while full SHALL be dropped without altering storage or pointers, and SHALL set input_fifo_overflow.
REQ-018 output_fifo_empty SHALL be low exactly when bank rd_bank is READY.
REQ-019 output_fifo_dout element k SHALL equal element rd_col of row k of bank rd_bank, for k = 0..N-1.
REQ-020 An effective pop SHALL increment rd_col; the pop at rd_col = N-1 SHALL set the bank FREE, toggle rd_bank and reset rd_col to 0.
REQ-021 A pop while empty SHALL be ignored; output_fifo_dout is don't-care while empty.
REQ-022 Latency: output_fifo_empty SHALL fall in the cycle after the edge that accepts row N-1.
REQ-023 With writes and pops both held high, throughput SHALL be one line per cycle each way, with no bubbles at tile boundaries.
REQ-024 A bank completing fill and the other bank being freed in the same cycle SHALL both take effect; neither event may be lost.
REQ-025 A write SHALL never modify the bank selected by rd_bank while that bank is READY.
REQ-026 Row and column counters SHALL be $clog2(N) bits and wrap from N-1 to 0.

Reset
REQ-027 Reset SHALL immediately clear both banks to FREE, wr_bank = rd_bank = 0, wr_row = rd_col = 0 and input_fifo_overflow = 0.
REQ-028 During reset: input_fifo_full = 0, output_fifo_empty = 1, output_fifo_dout = 0.
REQ-029 Reset mid-tile SHALL discard all partial and ready tiles; bank storage contents need not be cleared.

Structure
REQ-030 Package transpose_pkg SHALL hold the LINE_WIDTH default and the bank-state enum (FREE/FILLING/READY).
REQ-031 SHALL instantiate sub-module tile_bank twice; tile_bank holds N row registers, a row-write port and combinational column extraction.
REQ-032 Top level SHALL contain only the pointers, bank-state control, flags and the output bank mux.

Verification (DATA_WIDTH=16, N=32 unless noted)
REQ-033 One tile, row r element c = {r[7:0],c[7:0]}, pop continuously -> 32 lines; line c element k = {k,c}; empty falls one cycle after the 32nd write.
REQ-034 Three tiles written back-to-back with output_fifo_re held high -> 96 lines in order, no empty gaps after the first line, full never asserted.
REQ-035 64 writes with no pops -> full rises after the 64th write; 65th write dropped and overflow = 1; then 32 pops -> full falls and the next write is accepted.
REQ-036 Pop while empty, then reset asserted after 10 rows of a tile -> empty stays 1, pointers return to 0, and a fresh tile transposes correctly.
REQ-037 Write row 31 of tile B in the same cycle as the final pop of tile A -> tile B READY, bank A FREE, tile B output correct.
REQ-038 DATA_WIDTH=32 (N=16), repeat REQ-033 pattern -> 16 correct transposed lines.
